mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
- Parametrised pipeline MEM stage for the 5-stage CPU.
- Contains the data memory: synchronous write, asynchronous read, DEPTH words of 32 bits.
- Performs byte, halfword and word loads and stores with lane steering and sign/zero extension.
- Muxes forwarded store data and registers all results into the MEM/WB pipeline register, with stall and flush control.

Parameters:
- DEPTH, 256: number of 32-bit words in data memory; must be a power of 2.
- AW, 8: word-address width; must equal log2(DEPTH).
- RW, 5: destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX/MEM slot holds a real instruction
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- reg_write  in  1  instruction writes rd
- alu_out  in  32  byte address, or ALU result for non-memory instructions
- alu_b  in  32  raw store data from EX
- rd  in  RW  destination register
- fwd_sel  in  2  store-data source: 0 alu_b, 1 wb_load_data, 2 wb_alu_out, 3 alu_b
- stall  in  1  hold the MEM/WB register and suppress the memory write
- flush  in  1  squash the current slot (bubble into WB)
- wb_valid  out  1  registered: WB slot valid
- wb_reg_write  out  1  registered, already gated by wb_valid
- wb_mem_to_reg  out  1  registered copy of mem_read
- wb_rd  out  RW  registered
- wb_alu_out  out  32  registered
- wb_load_data  out  32  registered, extended load result; 0 if not a load
- misalign  out  1  combinational: current valid access is misaligned or has an illegal size

Behaviour:
- Reset (synchronous, on a clk edge with rst=1): every wb_* output goes to 0. Memory contents are NOT cleared. rst has priority over stall and flush.
- Word index: alu_out[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH. Byte lane: alu_out[1:0].
- acc = ex_valid & ~flush & ~misalign.
- misalign is asserted when ex_valid & (mem_read|mem_write) and any of:
  - mem_size==11;
  - mem_size==01 with alu_out[0]=1;
  - mem_size==10 with alu_out[1:0]!=0.
- Store data: st = alu_b / wb_load_data / wb_alu_out / alu_b for fwd_sel 0/1/2/3. Forwarding uses the current registered wb_* values, before the edge.
- Write: at the clk edge when acc & mem_write & ~stall & ~rst.
  - Byte: st[7:0] goes to lane alu_out[1:0].
  - Half: st[15:0] goes to lanes {alu_out[1],0}.
  - Word: all lanes are written.
  - Untouched lanes keep their value.
- Read: combinational from the word index.
  - Byte: lane selected, then sign- or zero-extended.
  - Half: halfword selected by alu_out[1], then extended.
  - Word: full word.
  - ld = extended value when acc & mem_read, else 0.
- Ordering: a load in the cycle after a store to the same word sees the new data. A combined mem_read & mem_write is treated as a store; ld is still computed from the pre-write data.
- MEM/WB register, evaluated at each edge:
  - rst: all outputs 0.
  - else stall: hold all outputs.
  - else: wb_valid<=acc | (ex_valid & ~flush & ~(mem_read|mem_write)); wb_reg_write<=reg_write & that valid term; wb_mem_to_reg<=mem_read; wb_rd<=rd; wb_alu_out<=alu_out; wb_load_data<=ld.
- Latency: one cycle from the EX/MEM inputs to the wb_* outputs.
- stall & flush together: stall wins; the flush is lost, and upstream must re-assert it.
- A misaligned access with the trap feature disabled becomes a bubble: no write, and wb_valid=0.

Optional Feature:
- Macro MEM_TRAP_EN.
- Defined:
  - Adds outputs wb_trap (1 bit) and wb_badaddr (32 bits).
  - A misaligned valid access that is not flushed sets, at the next non-stalled edge, wb_trap=1, wb_badaddr=alu_out, wb_valid=1, wb_reg_write=0; no memory write occurs.
  - Both outputs reset to 0 and hold under stall.
- Undefined: the ports are absent and misaligned accesses become silent bubbles as described above.

Test Plan:
- SW: store 0x12345678 at 0x10 (fwd_sel=0), then LW 0x10 -> wb_load_data=0x12345678, wb_mem_to_reg=1, one cycle after the load.
- SB: store 0xAB at 0x11 over 0x12345678, then LB 0x11 -> 0xFFFFFFAB; LBU 0x11 -> 0x000000AB; LW 0x10 -> 0x1234AB78.
- SH 0x8001 at 0x12, then LH -> 0xFFFF8001, LHU -> 0x00008001. SW at 0x13 -> misalign=1, memory unchanged, wb_valid=0; with MEM_TRAP_EN: wb_trap=1, wb_badaddr=0x13.
- Forwarding: wb_alu_out=0xCAFEF00D and fwd_sel=2, SW 0x20 -> LW 0x20 returns 0xCAFEF00D. With fwd_sel=1 and wb_load_data=0x55, the word stored is 0x55.
- Stall with SW 0x30 held 3 cycles -> no write and wb_* frozen. Release -> exactly one write. Flush on SW -> no write and wb_valid=0.
- Wrap: DEPTH=256, SW 0x400 then LW 0x0 -> same data. rst mid-stream -> all wb_* 0 next edge, memory contents retained.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: data memory with byte/half/word loads and stores, store-data forwarding, MEM/WB register.
// Optional feature macro MEM_TRAP_EN adds wb_trap/wb_badaddr for misaligned or illegal-size accesses.
module mem_stage_pipe #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int RW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_size,
    input  logic          mem_unsigned,
    input  logic          reg_write,
    input  logic [31:0]   alu_out,
    input  logic [31:0]   alu_b,
    input  logic [RW-1:0] rd,
    input  logic [1:0]    fwd_sel,
    input  logic          stall,
    input  logic          flush,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic          wb_mem_to_reg,
    output logic [RW-1:0] wb_rd,
    output logic [31:0]   wb_alu_out,
    output logic [31:0]   wb_load_data,
`ifdef MEM_TRAP_EN
    output logic          wb_trap,
    output logic [31:0]   wb_badaddr,
`endif
    output logic          misalign
);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_word_d;
    logic          mem_we;

    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          is_mem;
    logic          slot_live;
    logic          acc;
    logic [31:0]   st_data;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic [31:0]   ld;

    logic          wb_valid_q, wb_valid_d;
    logic          wb_reg_write_q, wb_reg_write_d;
    logic          wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [31:0]   wb_alu_out_q, wb_alu_out_d;
    logic [31:0]   wb_load_data_q, wb_load_data_d;
`ifdef MEM_TRAP_EN
    logic          wb_trap_q, wb_trap_d;
    logic [31:0]   wb_badaddr_q, wb_badaddr_d;
`endif

    always_comb begin
        widx      = alu_out[AW+1:2];
        lane      = alu_out[1:0];
        is_mem    = mem_read | mem_write;
        misalign  = ex_valid & is_mem &
                    ((mem_size == 2'b11) |
                     ((mem_size == 2'b01) & lane[0]) |
                     ((mem_size == 2'b10) & (lane != 2'b00)));
        slot_live = ex_valid & ~flush;
        acc       = slot_live & ~misalign;

        // Forwarding taps the MEM/WB register as it stands before this edge.
        case (fwd_sel)
            2'd1:    st_data = wb_load_data_q;
            2'd2:    st_data = wb_alu_out_q;
            default: st_data = alu_b;
        endcase

        rd_word    = mem_q[widx];
        mem_word_d = rd_word;
        case (mem_size)
            2'b00:   mem_word_d[{lane, 3'b000} +: 8]     = st_data[7:0];
            2'b01:   mem_word_d[{lane[1], 4'b0000} +: 16] = st_data[15:0];
            2'b10:   mem_word_d = st_data;
            default: mem_word_d = rd_word;
        endcase
        mem_we = acc & mem_write & ~stall & ~rst;

        // Load data comes from the pre-write word, so a combined read/write sees old data.
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = rd_word[{lane[1], 4'b0000} +: 16];
        case (mem_size)
            2'b00:   ld_ext = mem_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = mem_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            2'b10:   ld_ext = rd_word;
            default: ld_ext = 32'h0;
        endcase
        ld = (acc & mem_read) ? ld_ext : 32'h0;
    end

    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_alu_out_d    = wb_alu_out_q;
        wb_load_data_d  = wb_load_data_q;
`ifdef MEM_TRAP_EN
        wb_trap_d       = wb_trap_q;
        wb_badaddr_d    = wb_badaddr_q;
`endif
        if (!stall) begin
`ifdef MEM_TRAP_EN
            wb_valid_d   = slot_live;
            wb_trap_d    = slot_live & misalign;
            wb_badaddr_d = (slot_live & misalign) ? alu_out : 32'h0;
`else
            wb_valid_d   = acc;
`endif
            wb_reg_write_d  = reg_write & acc;
            wb_mem_to_reg_d = mem_read;
            wb_rd_d         = rd;
            wb_alu_out_d    = alu_out;
            wb_load_data_d  = ld;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[widx] <= mem_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_out_q    <= 32'h0;
            wb_load_data_q  <= 32'h0;
`ifdef MEM_TRAP_EN
            wb_trap_q       <= 1'b0;
            wb_badaddr_q    <= 32'h0;
`endif
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_alu_out_q    <= wb_alu_out_d;
            wb_load_data_q  <= wb_load_data_d;
`ifdef MEM_TRAP_EN
            wb_trap_q       <= wb_trap_d;
            wb_badaddr_q    <= wb_badaddr_d;
`endif
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_alu_out    = wb_alu_out_q;
    assign wb_load_data  = wb_load_data_q;
`ifdef MEM_TRAP_EN
    assign wb_trap       = wb_trap_q;
    assign wb_badaddr    = wb_badaddr_q;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed vector table, reset sequences and randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_mem_stage_pipe;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int RW     = 5;
    localparam int NBYTES = 4 * DEPTH;
`ifdef MEM_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, mem_read, mem_write, mem_unsigned, reg_write;
    logic [1:0]    mem_size, fwd_sel;
    logic [31:0]   alu_out, alu_b;
    logic [RW-1:0] rd;
    logic          stall, flush;
    logic          wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [RW-1:0] wb_rd;
    logic [31:0]   wb_alu_out, wb_load_data;
    logic          misalign;
`ifdef MEM_TRAP_EN
    logic          wb_trap;
    logic [31:0]   wb_badaddr;
`endif

    always #5 clk = ~clk;

    mem_stage_pipe #(.DEPTH(DEPTH), .AW(AW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .reg_write(reg_write), .alu_out(alu_out), .alu_b(alu_b), .rd(rd),
        .fwd_sel(fwd_sel), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .wb_alu_out(wb_alu_out), .wb_load_data(wb_load_data),
`ifdef MEM_TRAP_EN
        .wb_trap(wb_trap), .wb_badaddr(wb_badaddr),
`endif
        .misalign(misalign)
    );

    typedef struct {
        logic          ev, rdn, wrn, uns, rw, stl, fl;
        logic [1:0]    sz, fwd;
        logic [RW-1:0] rdi;
        logic [31:0]   addr, data;
        logic          e_valid, e_m2r, e_mis, e_trap;
        logic [31:0]   e_ld;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]    m_mem [NBYTES];
    logic          m_valid, m_rw, m_m2r, m_trap;
    logic [RW-1:0] m_rd;
    logic [31:0]   m_alu, m_ld, m_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        int ba, base;
        logic [31:0] v;
        ba = int'(addr % NBYTES);
        v  = 32'h0;
        if (sz == 2'd0) begin
            v = 32'(m_mem[ba]);
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            base = ba - (ba % 2);
            v = 32'(m_mem[base]) + 256 * 32'(m_mem[base + 1]);
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else if (sz == 2'd2) begin
            base = ba - (ba % 4);
            for (int k = 3; k >= 0; k--) v = v * 256 + 32'(m_mem[base + k]);
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] st);
        int ba, n, base;
        logic [31:0] tmp;
        ba   = int'(addr % NBYTES);
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = ba - (ba % n);
        for (int k = 0; k < n; k++) begin
            tmp = st >> (8 * k);
            m_mem[base + k] = tmp[7:0];
        end
    endtask

    task automatic check_wb(input string tag);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
        check({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(m_rw));
        check({tag, ".wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(m_m2r));
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(m_rd));
        check({tag, ".wb_alu_out"}, wb_alu_out, m_alu);
        check({tag, ".wb_load_data"}, wb_load_data, m_ld);
`ifdef MEM_TRAP_EN
        check({tag, ".wb_trap"}, 32'(wb_trap), 32'(m_trap));
        if (m_trap) check({tag, ".wb_badaddr"}, wb_badaddr, m_bad);
`endif
    endtask

    // One cycle: drive at negedge, check misalign, advance the model, check wb_* after the edge.
    task automatic apply(input vec_t v, input string tag, output logic mis_seen);
        logic mis, live, acc;
        logic [31:0] st, ldv;
        @(negedge clk);
        rst = 1'b0; ex_valid = v.ev; mem_read = v.rdn; mem_write = v.wrn;
        mem_size = v.sz; mem_unsigned = v.uns; reg_write = v.rw; rd = v.rdi;
        alu_out = v.addr; alu_b = v.data; fwd_sel = v.fwd; stall = v.stl; flush = v.fl;
        #1;
        mis  = v.ev && (v.rdn || v.wrn) &&
               (v.sz == 2'd3 || (v.sz == 2'd1 && v.addr % 2 != 0) || (v.sz == 2'd2 && v.addr % 4 != 0));
        live = v.ev && !v.fl;
        acc  = live && !mis;
        mis_seen = misalign;
        check({tag, ".misalign"}, 32'(misalign), 32'(mis));
        st  = (v.fwd == 2'd1) ? m_ld : (v.fwd == 2'd2) ? m_alu : v.data;
        ldv = (acc && v.rdn) ? model_load(v.addr, v.sz, v.uns) : 32'h0;
        if (acc && v.wrn && !v.stl) model_store(v.addr, v.sz, st);
        if (!v.stl) begin
            m_valid = TRAP ? live : acc;
            m_rw    = v.rw && acc;
            m_m2r   = v.rdn;
            m_rd    = v.rdi;
            m_alu   = v.addr;
            m_ld    = ldv;
            m_trap  = TRAP && live && mis;
            m_bad   = v.addr;
        end
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    // Reset while a store is presented: the store must not land and wb_* must clear.
    task automatic do_reset(input logic [31:0] junk_addr);
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd2;
        mem_unsigned = 1'b0; reg_write = 1'b1; rd = 5'd7; alu_out = junk_addr;
        alu_b = 32'hFFFF_FFFF; fwd_sel = 2'd0; stall = 1'b1; flush = 1'b1;
        m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = '0; m_alu = 0; m_ld = 0; m_trap = 0; m_bad = 0;
        @(posedge clk);
        #1;
        check_wb("reset");
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic ev, rdn, wrn, input logic [1:0] sz, input logic uns,
                                input logic [1:0] fwd, input logic stl, fl,
                                input logic [31:0] addr, data,
                                input logic e_valid, e_m2r, input logic [31:0] e_ld,
                                input logic e_mis, e_trap);
        vec_t v;
        v.ev = ev; v.rdn = rdn; v.wrn = wrn; v.sz = sz; v.uns = uns; v.fwd = fwd;
        v.stl = stl; v.fl = fl; v.addr = addr; v.data = data; v.rw = 1'b1; v.rdi = 5'd3;
        v.e_valid = e_valid; v.e_m2r = e_m2r; v.e_ld = e_ld; v.e_mis = e_mis; v.e_trap = e_trap;
        return v;
    endfunction

    vec_t tab [30];

    initial begin
        vec_t v;
        logic ms;
        int op;

        tab[0]  = mk(1,0,1,2,0,0,0,0,32'h10,32'h1234_5678, 1,0,32'h0,0,0);
        tab[1]  = mk(1,1,0,2,0,0,0,0,32'h10,32'h0,         1,1,32'h1234_5678,0,0);
        tab[2]  = mk(1,0,1,0,0,0,0,0,32'h11,32'hAB,        1,0,32'h0,0,0);
        tab[3]  = mk(1,1,0,0,0,0,0,0,32'h11,32'h0,         1,1,32'hFFFF_FFAB,0,0);
        tab[4]  = mk(1,1,0,0,1,0,0,0,32'h11,32'h0,         1,1,32'h0000_00AB,0,0);
        tab[5]  = mk(1,1,0,2,0,0,0,0,32'h10,32'h0,         1,1,32'h1234_AB78,0,0);
        tab[6]  = mk(1,0,1,1,0,0,0,0,32'h12,32'h8001,      1,0,32'h0,0,0);
        tab[7]  = mk(1,1,0,1,0,0,0,0,32'h12,32'h0,         1,1,32'hFFFF_8001,0,0);
        tab[8]  = mk(1,1,0,1,1,0,0,0,32'h12,32'h0,         1,1,32'h0000_8001,0,0);
        tab[9]  = mk(1,0,1,2,0,0,0,0,32'h13,32'hDEAD_BEEF, TRAP,0,32'h0,1,TRAP);
        tab[10] = mk(1,1,0,2,0,0,0,0,32'h10,32'h0,         1,1,32'h8001_AB78,0,0);
        tab[11] = mk(1,0,0,2,0,0,0,0,32'hCAFE_F00D,32'h0,  1,0,32'h0,0,0);
        tab[12] = mk(1,0,1,2,0,2,0,0,32'h20,32'h0,         1,0,32'h0,0,0);
        tab[13] = mk(1,1,0,2,0,0,0,0,32'h20,32'h0,         1,1,32'hCAFE_F00D,0,0);
        tab[14] = mk(1,0,1,2,0,0,0,0,32'h24,32'h55,        1,0,32'h0,0,0);
        tab[15] = mk(1,1,0,2,0,0,0,0,32'h24,32'h0,         1,1,32'h55,0,0);
        tab[16] = mk(1,0,1,2,0,1,0,0,32'h28,32'h9999_9999, 1,0,32'h0,0,0);
        tab[17] = mk(1,1,0,2,0,0,0,0,32'h28,32'h0,         1,1,32'h55,0,0);
        tab[18] = mk(1,0,1,2,0,0,1,0,32'h30,32'h1111_1111, 1,1,32'h55,0,0);
        tab[19] = mk(1,0,1,2,0,0,1,0,32'h30,32'h1111_1111, 1,1,32'h55,0,0);
        tab[20] = mk(1,0,1,2,0,0,1,0,32'h30,32'h1111_1111, 1,1,32'h55,0,0);
        tab[21] = mk(1,1,0,2,0,0,0,0,32'h30,32'h0,         1,1,32'h1000_000C,0,0);
        tab[22] = mk(1,0,1,2,0,0,0,0,32'h30,32'h1111_1111, 1,0,32'h0,0,0);
        tab[23] = mk(1,1,0,2,0,0,0,0,32'h30,32'h0,         1,1,32'h1111_1111,0,0);
        tab[24] = mk(1,0,1,2,0,0,0,1,32'h34,32'h2222_2222, 0,0,32'h0,0,0);
        tab[25] = mk(1,1,0,2,0,0,0,0,32'h34,32'h0,         1,1,32'h1000_000D,0,0);
        tab[26] = mk(1,0,1,2,0,0,0,0,32'h400,32'h7654_3210,1,0,32'h0,0,0);
        tab[27] = mk(1,1,0,2,0,0,0,0,32'h0,32'h0,          1,1,32'h7654_3210,0,0);
        tab[28] = mk(1,0,1,2,0,0,1,1,32'h4,32'hEEEE_EEEE,  1,1,32'h7654_3210,0,0);
        tab[29] = mk(1,1,0,2,0,0,0,0,32'h4,32'h0,          1,1,32'h1000_0001,0,0);

        rst = 1'b1; ex_valid = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
        reg_write = 0; rd = '0; alu_out = 0; alu_b = 0; fwd_sel = 0; stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        do_reset(32'h0);

        // Known contents everywhere so random loads never see uninitialised words.
        for (int i = 0; i < DEPTH; i++) begin
            v = mk(1,0,1,2,0,0,0,0,32'(4 * i),32'h1000_0000 + 32'(i), 0,0,0,0,0);
            apply(v, "init", ms);
        end

        for (int i = 0; i < 30; i++) begin
            apply(tab[i], $sformatf("vec%0d", i), ms);
            check($sformatf("vec%0d.exp_valid", i), 32'(wb_valid), 32'(tab[i].e_valid));
            check($sformatf("vec%0d.exp_m2r", i), 32'(wb_mem_to_reg), 32'(tab[i].e_m2r));
            check($sformatf("vec%0d.exp_ld", i), wb_load_data, tab[i].e_ld);
            check($sformatf("vec%0d.exp_mis", i), 32'(ms), 32'(tab[i].e_mis));
`ifdef MEM_TRAP_EN
            check($sformatf("vec%0d.exp_trap", i), 32'(wb_trap), 32'(tab[i].e_trap));
            if (tab[i].e_trap) check($sformatf("vec%0d.exp_badaddr", i), wb_badaddr, tab[i].addr);
`endif
        end

        // Mid-stream reset: outputs clear, memory keeps the word written by vec26.
        do_reset(32'h0);
        apply(mk(1,1,0,2,0,0,0,0,32'h0,32'h0, 1,1,32'h7654_3210,0,0), "post_rst", ms);
        check("post_rst.retained", wb_load_data, 32'h7654_3210);

        for (int i = 0; i < 1500; i++) begin
            op    = int'($urandom_range(0, 3));
            v.ev  = ($urandom_range(0, 9) != 0);
            v.rdn = (op == 1 || op == 3);
            v.wrn = (op == 2 || op == 3);
            v.sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.uns = 1'($urandom_range(0, 1));
            v.rw  = 1'($urandom_range(0, 1));
            v.rdi = RW'($urandom());
            v.fwd = 2'($urandom_range(0, 3));
            v.stl = ($urandom_range(0, 7) == 0);
            v.fl  = ($urandom_range(0, 7) == 0);
            v.addr = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (v.sz == 2'd1) v.addr[0] = 1'b0;
                if (v.sz == 2'd2) v.addr[1:0] = 2'b00;
            end
            v.data = $urandom();
            if (i == 700) do_reset(v.addr);
            apply(v, "rand", ms);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
